led_timer_bank: RTL and testbench

//  Multi-channel LED timer: each of LED_COUNT outputs is lit for a per-request duration, in one of three modes.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_channel.sv | 83 ++++++++
 rtl/led_timer_bank.sv | 83 ++++++++
 tb/tb_led_timer_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared mode encodings and sizing helpers for the LED timer bank.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_CANCEL    = 2'b00,
    MODE_ONESHOT   = 2'b01,
    MODE_RETRIGGER = 2'b10,
    MODE_BLINK     = 2'b11
  } led_mode_e;

  function automatic int unsigned tick_cycles(input int unsigned period_ns);
    return 1_000_000 / period_ns;
  endfunction

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED timer channel: ms countdown, optional blink phase, registered LED.
module led_channel
  import led_pkg::*;
#(
  parameter int DUR_W         = 16,
  parameter int BLINK_HALF_MS = 250
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  led_mode_e        mode,
  input  logic [DUR_W-1:0] dur,
  input  logic             cancel,
  output logic             led,
  output logic             busy
);

  localparam int BW = cnt_w(BLINK_HALF_MS);
  localparam logic [BW-1:0] HALF_LAST = BW'(BLINK_HALF_MS - 1);
  localparam logic [DUR_W-1:0] ONE = DUR_W'(1);

  logic [DUR_W-1:0] rem;
  logic [BW-1:0]    blink_cnt;
  logic             blink;

  assign busy = (rem != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem       <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      led       <= 1'b0;
    end else if (cancel) begin
      rem       <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      led       <= 1'b0;
    end else if (load) begin
      // A load on a tick edge wins; the fresh value is not decremented.
      unique case (mode)
        MODE_CANCEL: begin
          rem   <= '0;
          blink <= 1'b0;
          led   <= 1'b0;
        end
        MODE_ONESHOT: begin
          if (rem == '0) begin
            rem       <= dur;
            blink_cnt <= '0;
            blink     <= 1'b0;
            led       <= 1'b1;
          end
        end
        MODE_RETRIGGER: begin
          rem   <= dur;
          blink <= 1'b0;
          led   <= 1'b1;
        end
        MODE_BLINK: begin
          rem       <= dur;
          blink_cnt <= '0;
          blink     <= 1'b1;
          led       <= 1'b1;
        end
      endcase
    end else if (tick && busy) begin
      rem <= rem - ONE;
      if (rem == ONE) begin
        led <= 1'b0;
      end else if (blink) begin
        if (blink_cnt == HALF_LAST) begin
          blink_cnt <= '0;
          led       <= ~led;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_timer_bank.sv
// Bank of LED timers sharing one ms prescaler, fed by a valid/ready request port.
module led_timer_bank
  import led_pkg::*;
#(
  parameter int CLK_PERIOD_NS = 50,
  parameter int LED_COUNT     = 18,
  parameter int IDX_W         = 5,
  parameter int DUR_W         = 16,
  parameter int DEFAULT_MS    = 10000,
  parameter int BLINK_HALF_MS = 250
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDX_W-1:0]     req_index,
  input  logic [1:0]           req_mode,
  input  logic [DUR_W-1:0]     req_duration,
  input  logic                 clear_all,
  output logic [LED_COUNT-1:0] LEDR,
  output logic [LED_COUNT-1:0] busy,
  output logic                 req_err
);

  localparam int TICK_CYCLES = tick_cycles(CLK_PERIOD_NS);
  localparam int PW = cnt_w(TICK_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [DUR_W-1:0] DEF_D = DUR_W'(DEFAULT_MS);

  if (TICK_CYCLES < 1) begin : g_bad_tick
    $error("CLK_PERIOD_NS too large: less than one cycle per ms");
  end
  if ((DEFAULT_MS >> DUR_W) != 0) begin : g_bad_default
    $error("DEFAULT_MS does not fit in DUR_W bits");
  end
  if (LED_COUNT > (1 << IDX_W)) begin : g_bad_idx
    $error("IDX_W too narrow for LED_COUNT");
  end
  if (BLINK_HALF_MS < 1) begin : g_bad_blink
    $error("BLINK_HALF_MS must be at least 1");
  end

  logic [PW-1:0]    pre;
  logic             tick;
  logic             accept;
  logic             in_range;
  logic [DUR_W-1:0] dur_eff;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre <= '0;
    else     pre <= tick ? '0 : pre + 1'b1;
  end

  assign req_ready = ~rst & ~clear_all;
  assign accept    = req_valid & req_ready;
  assign in_range  = 32'(req_index) < 32'(LED_COUNT);
  assign dur_eff   = (req_duration == '0) ? DEF_D : req_duration;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_err <= 1'b0;
    else     req_err <= accept & ~in_range;
  end

  for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
    led_channel #(
      .DUR_W         (DUR_W),
      .BLINK_HALF_MS (BLINK_HALF_MS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .load   (accept & in_range & (req_index == IDX_W'(i))),
      .mode   (led_mode_e'(req_mode)),
      .dur    (dur_eff),
      .cancel (clear_all),
      .led    (LEDR[i]),
      .busy   (busy[i])
    );
  end

endmodule

// File: tb/tb_led_timer_bank.sv
// Directed self-checking bench for led_timer_bank (4 cycles per ms tick).
module tb_led_timer_bank;

  localparam int LC = 18;
  localparam int IW = 5;
  localparam int DW = 16;
  localparam logic [1:0] M_CAN = 2'b00;
  localparam logic [1:0] M_ONE = 2'b01;
  localparam logic [1:0] M_RET = 2'b10;
  localparam logic [1:0] M_BLK = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_index = '0;
  logic [1:0]    req_mode = '0;
  logic [DW-1:0] req_duration = '0;
  logic          clear_all = 1'b0;
  logic [LC-1:0] LEDR;
  logic [LC-1:0] busy;
  logic          req_err;

  int n_chk  = 0;
  int n_fail = 0;
  int pc;

  led_timer_bank #(
    .CLK_PERIOD_NS (250_000),
    .LED_COUNT     (LC),
    .IDX_W         (IW),
    .DUR_W         (DW),
    .DEFAULT_MS    (8),
    .BLINK_HALF_MS (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_index    (req_index),
    .req_mode     (req_mode),
    .req_duration (req_duration),
    .clear_all    (clear_all),
    .LEDR         (LEDR),
    .busy         (busy),
    .req_err      (req_err)
  );

  always #5 clk = ~clk;

  // Reference prescaler: a tick edge follows any cycle where pc == 3.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 0;
    else     pc <= (pc == 3) ? 0 : pc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send(input int idx, input logic [1:0] m, input int d);
    req_valid    = 1'b1;
    req_index    = IW'(idx);
    req_mode     = m;
    req_duration = DW'(d);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic align_tick();
    int g;
    g = 0;
    while (pc != 3 && g < 8) begin
      @(negedge clk);
      g++;
    end
    if (g >= 8) chk("tick_timeout", 0, 1);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      align_tick();
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] pat;
    int cnt;
    pat = 8'b0011_0011;

    #12;
    chk("rst_ledr", 32'(LEDR), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(req_err), 0);
    chk("rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_idle", 32'(req_ready), 1);
    @(negedge clk);

    // One-shot length in cycles
    send(3, M_ONE, 5);
    chk("os_on", 32'(LEDR[3]), 1);
    chk("os_busy", 32'(busy[3]), 1);
    cnt = 0;
    for (int k = 0; k < 40 && LEDR[3]; k++) begin
      cnt++;
      @(negedge clk);
    end
    chk("os_len_ok", 32'(cnt >= 17 && cnt <= 20), 1);
    chk("os_busy_off", 32'(busy[3]), 0);

    // One-shot ignores a second one-shot while active
    wait_ticks(1);
    send(3, M_ONE, 5);
    wait_ticks(2);
    send(3, M_ONE, 20);
    chk("os2_err", 32'(req_err), 0);
    wait_ticks(2);
    chk("os2_on4", 32'(LEDR[3]), 1);
    wait_ticks(1);
    chk("os2_off5", 32'(LEDR[3]), 0);
    chk("os2_busy5", 32'(busy[3]), 0);

    // Retrigger reloads
    wait_ticks(1);
    send(3, M_RET, 5);
    wait_ticks(2);
    send(3, M_RET, 20);
    wait_ticks(19);
    chk("rt_on19", 32'(LEDR[3]), 1);
    chk("rt_busy19", 32'(busy[3]), 1);
    wait_ticks(1);
    chk("rt_off20", 32'(LEDR[3]), 0);

    // Blink pattern
    wait_ticks(1);
    send(0, M_BLK, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("blk_led%0d", i), 32'(LEDR[0]), 32'(pat[i]));
      chk($sformatf("blk_busy%0d", i), 32'(busy[0]), 1);
      wait_ticks(1);
    end
    chk("blk_end_led", 32'(LEDR[0]), 0);
    chk("blk_end_busy", 32'(busy[0]), 0);

    // Default duration
    wait_ticks(1);
    send(17, M_ONE, 0);
    wait_ticks(7);
    chk("def_on7", 32'(LEDR[17]), 1);
    wait_ticks(1);
    chk("def_off8", 32'(LEDR[17]), 0);

    // Out-of-range index
    send(18, M_BLK, 4);
    chk("oor_err", 32'(req_err), 1);
    chk("oor_ledr", 32'(LEDR), 0);
    chk("oor_busy", 32'(busy), 0);
    @(negedge clk);
    chk("oor_err_clr", 32'(req_err), 0);

    // Accept on a tick edge; another channel expires on the same edge
    wait_ticks(1);
    send(6, M_ONE, 3);
    wait_ticks(2);
    align_tick();
    send(5, M_ONE, 2);
    chk("co_ch6_off", 32'(LEDR[6]), 0);
    chk("co_ch5_on", 32'(LEDR[5]), 1);
    wait_ticks(1);
    chk("co_ch5_t1", 32'(LEDR[5]), 1);
    wait_ticks(1);
    chk("co_ch5_t2", 32'(LEDR[5]), 0);

    // Cancel
    send(9, M_RET, 10);
    send(9, M_CAN, 0);
    chk("cancel_led", 32'(LEDR[9]), 0);
    chk("cancel_busy", 32'(busy[9]), 0);

    // clear_all with a concurrent request
    send(1, M_RET, 10);
    send(2, M_BLK, 10);
    send(4, M_ONE, 10);
    chk("ca_pre", 32'(LEDR), 32'h16);
    clear_all    = 1'b1;
    req_valid    = 1'b1;
    req_index    = IW'(7);
    req_mode     = M_ONE;
    req_duration = DW'(5);
    #1;
    chk("ca_ready", 32'(req_ready), 0);
    @(negedge clk);
    clear_all = 1'b0;
    req_valid = 1'b0;
    chk("ca_ledr", 32'(LEDR), 0);
    chk("ca_busy", 32'(busy), 0);
    #1;
    chk("ca_ready_back", 32'(req_ready), 1);
    @(negedge clk);

    // Asynchronous reset mid-blink
    send(0, M_BLK, 8);
    wait_ticks(1);
    chk("ar_pre", 32'(LEDR[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ledr", 32'(LEDR), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_after", 32'(LEDR), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
